// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point types and helpers for the FP datapath blocks
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
        logic zero;
    } flags_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in 128 bits: {0, all-ones exponent, 1, zeros}
    function automatic logic [127:0] qnan_bits(input int exp_w, input int man_w);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

    function automatic fp_class_e classify(input logic flush, input logic exp_ones,
                                           input logic frac_zero);
        if (flush) begin
            return FP_ZERO;
        end else if (exp_ones) begin
            return frac_zero ? FP_INF : FP_NAN;
        end
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter; all-zero input yields WIDTH
module fp_lzc #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0]             data,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Scan upward so the highest set bit is the last to write the count
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - pipelined IEEE-754 add/subtract, RNE, flush-to-zero, 3-cycle latency
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    parameter bit  FTZ   = 1'b1,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_zero,
    output logic         flag_overflow,
    output logic         flag_underflow,
    output logic         flag_invalid,
    output logic         flag_inexact
);

    localparam int SW  = MAN_W + 4;
    localparam int SUMW = MAN_W + 5;
    localparam int LZW = $clog2(SW + 1);
    localparam int EW  = EXP_W + 2;
    localparam int MW  = EXP_W + MAN_W;
    localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic stall, accept, ready_q;

    assign stall    = out_valid && !out_ready;
    assign in_ready = ready_q && !stall;
    assign accept   = in_valid && in_ready;

    // Input capture rank
    logic         s0_valid, s0_op;
    logic [W-1:0] s0_a, s0_b;

    // Unpack / align
    logic               sa, sb;
    fp_class_e          cls_a, cls_b;
    logic [MW-1:0]      mag_a, mag_b, big_mag, sml_mag;
    logic               swap, big_sign, sml_sign;
    logic [EXP_W-1:0]   big_exp, sml_exp, shift;
    logic [SW-1:0]      sig_big, sig_sml, aligned;
    logic [2*SW-1:0]    ext;
    logic               spec;
    logic [W-1:0]       spec_res;
    flags_t             spec_flags;

    assign sa    = s0_a[W-1];
    assign sb    = s0_b[W-1] ^ s0_op;
    assign cls_a = classify((s0_a[MW-1:MAN_W] == '0) && (FTZ || s0_a[MAN_W-1:0] == '0),
                            &s0_a[MW-1:MAN_W], s0_a[MAN_W-1:0] == '0);
    assign cls_b = classify((s0_b[MW-1:MAN_W] == '0) && (FTZ || s0_b[MAN_W-1:0] == '0),
                            &s0_b[MW-1:MAN_W], s0_b[MAN_W-1:0] == '0);

    always_comb begin
        mag_a    = (cls_a == FP_ZERO) ? '0 : s0_a[MW-1:0];
        mag_b    = (cls_b == FP_ZERO) ? '0 : s0_b[MW-1:0];
        swap     = mag_b > mag_a;
        big_mag  = swap ? mag_b : mag_a;
        sml_mag  = swap ? mag_a : mag_b;
        big_sign = swap ? sb : sa;
        sml_sign = swap ? sa : sb;
        big_exp  = big_mag[MW-1:MAN_W];
        sml_exp  = sml_mag[MW-1:MAN_W];
        sig_big  = {|big_exp, big_mag[MAN_W-1:0], 3'b000};
        sig_sml  = {|sml_exp, sml_mag[MAN_W-1:0], 3'b000};
        shift    = big_exp - sml_exp;
        ext      = {sig_sml, {SW{1'b0}}} >> shift;
        if (32'(shift) >= MAN_W + 3) begin
            aligned = {{(SW-1){1'b0}}, |sig_sml};
        end else begin
            aligned = {ext[2*SW-1:SW+1], ext[SW] | (|ext[SW-1:0])};
        end
    end

    always_comb begin
        spec       = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (cls_a == FP_NAN || cls_b == FP_NAN ||
            (cls_a == FP_INF && cls_b == FP_INF && sa != sb)) begin
            spec_res           = QNAN;
            spec_flags.invalid = 1'b1;
        end else if (cls_a == FP_INF) begin
            spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_b == FP_INF) begin
            spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_a == FP_ZERO && cls_b == FP_ZERO) begin
            spec_res        = {sa & sb, {MW{1'b0}}};
            spec_flags.zero = 1'b1;
        end else begin
            spec = 1'b0;
        end
    end

    logic               s1_valid, s1_spec, s1_sign, s1_eff_sub;
    logic [W-1:0]       s1_spec_res;
    flags_t             s1_spec_flags;
    logic [EXP_W-1:0]   s1_exp;
    logic [SW-1:0]      s1_sig_big, s1_sig_sml;

    // Add / subtract; the larger magnitude is always on the left so no negative results
    logic [SUMW-1:0] sum;
    logic [LZW-1:0]  lzc;

    assign sum = s1_eff_sub ? ({1'b0, s1_sig_big} - {1'b0, s1_sig_sml})
                            : ({1'b0, s1_sig_big} + {1'b0, s1_sig_sml});

    fp_lzc #(.WIDTH(SW)) u_lzc (
        .data  (sum[SW-1:0]),
        .count (lzc)
    );

    logic               s2_valid, s2_spec, s2_sign;
    logic [W-1:0]       s2_spec_res;
    flags_t             s2_spec_flags;
    logic [EXP_W-1:0]   s2_exp;
    logic [SUMW-1:0]    s2_sum;
    logic [LZW-1:0]     s2_lzc;

    // Normalise / round / pack
    logic [SW-1:0]          norm;
    logic signed [EW-1:0]   exp_n, exp_r;
    logic                   rnd_inc, grs;
    logic [MAN_W+1:0]       rnd;
    logic [MAN_W-1:0]       frac;
    logic [W-1:0]           res_d;
    flags_t                 flags_d;

    always_comb begin
        if (s2_sum[SW]) begin
            norm  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
            exp_n = EW'(s2_exp) + EW'(1);
        end else begin
            norm  = s2_sum[SW-1:0] << s2_lzc;
            exp_n = EW'(s2_exp) - EW'(s2_lzc);
        end
        grs     = |norm[2:0];
        rnd_inc = norm[2] && (norm[1] || norm[0] || norm[3]);
        rnd     = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rnd_inc);
        if (rnd[MAN_W+1]) begin
            exp_r = exp_n + EW'(1);
            frac  = rnd[MAN_W:1];
        end else begin
            exp_r = exp_n;
            frac  = rnd[MAN_W-1:0];
        end

        res_d   = '0;
        flags_d = '0;
        if (s2_spec) begin
            res_d   = s2_spec_res;
            flags_d = s2_spec_flags;
        end else if (s2_sum == '0) begin
            flags_d.zero = 1'b1;
        end else if (exp_r >= EXP_MAX) begin
            res_d            = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d.overflow = 1'b1;
            flags_d.inexact  = 1'b1;
        end else if (exp_r[EW-1] || exp_r == '0) begin
            res_d             = {s2_sign, {MW{1'b0}}};
            flags_d.underflow = 1'b1;
            flags_d.inexact   = 1'b1;
            flags_d.zero      = 1'b1;
        end else begin
            res_d           = {s2_sign, exp_r[EXP_W-1:0], frac};
            flags_d.inexact = grs;
        end
    end

    flags_t out_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q       <= 1'b0;
            s0_valid      <= 1'b0;
            s0_op         <= 1'b0;
            s0_a          <= '0;
            s0_b          <= '0;
            s1_valid      <= 1'b0;
            s1_spec       <= 1'b0;
            s1_sign       <= 1'b0;
            s1_eff_sub    <= 1'b0;
            s1_spec_res   <= '0;
            s1_spec_flags <= '0;
            s1_exp        <= '0;
            s1_sig_big    <= '0;
            s1_sig_sml    <= '0;
            s2_valid      <= 1'b0;
            s2_spec       <= 1'b0;
            s2_sign       <= 1'b0;
            s2_spec_res   <= '0;
            s2_spec_flags <= '0;
            s2_exp        <= '0;
            s2_sum        <= '0;
            s2_lzc        <= '0;
            out_valid     <= 1'b0;
            result        <= '0;
            out_flags     <= '0;
        end else begin
            ready_q <= 1'b1;
            if (!stall) begin
                s0_valid <= accept;
                if (accept) begin
                    s0_a  <= a;
                    s0_b  <= b;
                    s0_op <= op;
                end
                s1_valid      <= s0_valid;
                s1_spec       <= spec;
                s1_sign       <= big_sign;
                s1_eff_sub    <= big_sign ^ sml_sign;
                s1_spec_res   <= spec_res;
                s1_spec_flags <= spec_flags;
                s1_exp        <= big_exp;
                s1_sig_big    <= sig_big;
                s1_sig_sml    <= aligned;
                s2_valid      <= s1_valid;
                s2_spec       <= s1_spec;
                s2_sign       <= s1_sign;
                s2_spec_res   <= s1_spec_res;
                s2_spec_flags <= s1_spec_flags;
                s2_exp        <= s1_exp;
                s2_sum        <= sum;
                s2_lzc        <= lzc;
                out_valid     <= s2_valid;
                result        <= res_d;
                out_flags     <= flags_d;
            end
        end
    end

    assign flag_zero      = out_flags.zero;
    assign flag_overflow  = out_flags.overflow;
    assign flag_underflow = out_flags.underflow;
    assign flag_invalid   = out_flags.invalid;
    assign flag_inexact   = out_flags.inexact;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - directed vector bench for fp_addsub_pipe (binary32)
module tb_fp_addsub_pipe;

    localparam logic [4:0] F_INV = 5'b10000;
    localparam logic [4:0] F_OVF = 5'b01000;
    localparam logic [4:0] F_UNF = 5'b00100;
    localparam logic [4:0] F_INX = 5'b00010;
    localparam logic [4:0] F_ZER = 5'b00001;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        flag_zero, flag_overflow, flag_underflow, flag_invalid, flag_inexact;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .op             (op),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_zero      (flag_zero),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_invalid   (flag_invalid),
        .flag_inexact   (flag_inexact)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] flags_now();
        return {flag_invalid, flag_overflow, flag_underflow, flag_inexact, flag_zero};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string n, input logic [31:0] va, input logic [31:0] vb,
                           input logic vop, input logic [31:0] vr, input logic [4:0] vf);
        vecs.push_back('{n, va, vb, vop, vr, vf});
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        a        = v.a;
        b        = v.b;
        op       = v.op;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({v.name, " latency"}, lat, 3);
        chk({v.name, " result"}, result, v.res);
        chk({v.name, " flags"}, {27'd0, flags_now()}, {27'd0, v.fl});
        step();
    endtask

    logic [31:0] bp_a[6]   = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] bp_exp[6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000};

    initial begin
        int issued, got, last_cyc, seen;
        logic [31:0] held;
        logic was_stalled;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset flags", flags_now(), 0);
        chk("reset in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("in_ready before first edge", in_ready, 0);
        step();
        chk("in_ready after reset", in_ready, 1);

        add_vec("add 1+2",       32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'b0);
        add_vec("cancel 1-1",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, F_ZER);
        add_vec("underflow",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, F_UNF | F_INX | F_ZER);
        add_vec("tie even down", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, F_INX);
        add_vec("above half",    32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, F_INX);
        add_vec("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, F_OVF | F_INX);
        add_vec("inf-inf",       32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, F_INV);
        add_vec("-inf+1",        32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 5'b0);
        add_vec("1+(-1)",        32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, F_ZER);
        add_vec("-0+-0",         32'h80000000, 32'h80000000, 1'b0, 32'h80000000, F_ZER);
        add_vec("-0--0",         32'h80000000, 32'h80000000, 1'b1, 32'h00000000, F_ZER);
        add_vec("nan+1",         32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, F_INV);
        add_vec("3-1",           32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 5'b0);
        add_vec("subnormal in",  32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 5'b0);
        add_vec("1+1 carry",     32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'b0);
        add_vec("exact ulp",     32'h3FC00000, 32'h34000000, 1'b0, 32'h3FC00001, 5'b0);
        add_vec("tie even up",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, F_INX);
        add_vec("round carry",   32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, F_INX);
        add_vec("round ovf",     32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, F_OVF | F_INX);
        add_vec("1-2 negative",  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 5'b0);
        add_vec("min normal x2", 32'h00800000, 32'h00800000, 1'b0, 32'h01000000, 5'b0);
        add_vec("inf+inf",       32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 5'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: six back-to-back ops, downstream stalls cycles 4..9
        issued = 0; got = 0; last_cyc = -1; held = '0; was_stalled = 1'b0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c <= 9);
            in_valid  = issued < 6;
            a         = bp_a[issued < 6 ? issued : 0];
            b         = 32'h3F800000;
            op        = 1'b0;
            #1;
            if (in_valid && in_ready) issued++;
            if (out_valid && !out_ready) begin
                chk($sformatf("bp in_ready stalled c%0d", c), in_ready, 0);
                if (was_stalled) chk($sformatf("bp held c%0d", c), result, held);
                held = result;
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (got < 6) begin
                    chk($sformatf("bp out%0d", got), result, bp_exp[got]);
                    if (got > 0) chk($sformatf("bp gap out%0d", got), c - last_cyc, 1);
                    last_cyc = c;
                end else begin
                    chk("bp extra output", got, 5);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp output count", got, 6);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            a = bp_a[i]; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst out_valid async", out_valid, 0);
        step();
        chk("midrst out_valid next", out_valid, 0);
        chk("midrst in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("midrst nothing emitted", seen, 0);
        chk("midrst in_ready back", in_ready, 1);
        run_vec('{"after reset 2+3", 32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 5'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
